// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: streams one image from memory into the conv/maxpool datapath, then waits for its outputs.
// Define SEQ_CYCLE_COUNT_EN to add the frame_cycles latency counter output.
module conv_frame_sequencer #(
    parameter int IMG_W         = 28,
    parameter int IMG_H         = 28,
    parameter int KERNEL        = 3,
    parameter int POOL          = 2,
    parameter int ADDR_W        = 10,
    parameter int CNT_W         = 10,
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_data,
    output logic [7:0]        pixel_out,
    output logic              pixel_valid,
    input  logic              con_valid,
    input  logic              max_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overrun,
    output logic [CNT_W-1:0]  con_count,
    output logic [CNT_W-1:0]  max_count
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]       frame_cycles
`endif
);

    localparam int PIXELS    = IMG_W * IMG_H;
    localparam int CONV_OUTS = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);
    localparam int POOL_OUTS = ((IMG_W - KERNEL + 1) / POOL) * ((IMG_H - KERNEL + 1) / POOL);
    localparam int DRAIN_W   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]   CONV_TARGET = CNT_W'(CONV_OUTS);
    localparam logic [CNT_W-1:0]   POOL_TARGET = CNT_W'(POOL_OUTS);
    localparam logic [DRAIN_W-1:0] DRAIN_LIMIT = DRAIN_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_pixelValid;
    logic [7:0]         r_pixelHold;
    logic [CNT_W-1:0]   r_conCount;
    logic [CNT_W-1:0]   r_maxCount;
    logic [DRAIN_W-1:0] r_drainCnt;
    logic               r_timeout;
    logic               r_overrun;

    logic               w_startAccept;
    logic               w_setTimeout;
    logic               w_counting;
    logic               w_countsMet;
    logic [DRAIN_W-1:0] w_drainNext;

    assign w_counting  = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign w_countsMet = (r_conCount == CONV_TARGET) && (r_maxCount == POOL_TARGET);
    assign w_drainNext = r_drainCnt + DRAIN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Completion wins over an expiring drain timer in the same cycle.
    always_comb begin
        w_nextState   = r_state;
        mem_rd_en     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        w_startAccept = 1'b0;
        w_setTimeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_startAccept = 1'b1;
                    w_nextState   = S_STREAM;
                end
            end
            S_STREAM: begin
                mem_rd_en = !stall;
                if (!stall && (r_addr == LAST_ADDR)) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_countsMet) begin
                    w_nextState = S_DONE;
                end else if (w_drainNext == DRAIN_LIMIT) begin
                    w_setTimeout = 1'b1;
                    w_nextState  = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr       <= '0;
            r_pixelValid <= 1'b0;
            r_pixelHold  <= '0;
            r_conCount   <= '0;
            r_maxCount   <= '0;
            r_drainCnt   <= '0;
            r_timeout    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_pixelValid <= mem_rd_en;
            if (r_pixelValid) begin
                r_pixelHold <= mem_data;
            end
            r_drainCnt <= (r_state == S_DRAIN) ? w_drainNext : '0;
            if (w_startAccept) begin
                r_addr     <= '0;
                r_conCount <= '0;
                r_maxCount <= '0;
                r_timeout  <= 1'b0;
                r_overrun  <= 1'b0;
            end else begin
                if (mem_rd_en) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                // Counts saturate at the frame's expected total; anything beyond is an overrun.
                if (w_counting && con_valid) begin
                    if (r_conCount == CONV_TARGET) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_conCount <= r_conCount + CNT_W'(1);
                    end
                end
                if (w_counting && max_valid) begin
                    if (r_maxCount == POOL_TARGET) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_maxCount <= r_maxCount + CNT_W'(1);
                    end
                end
                if (w_setTimeout) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] r_frameCycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frameCycles <= '0;
        end else if (w_startAccept) begin
            r_frameCycles <= '0;
        end else if (w_counting && (r_frameCycles != 16'hFFFF)) begin
            r_frameCycles <= r_frameCycles + 16'd1;
        end
    end

    assign frame_cycles = r_frameCycles;
`endif

    // Memory data already arrives registered, so the valid cycle passes it through and the hold register covers gaps.
    assign pixel_out   = r_pixelValid ? mem_data : r_pixelHold;
    assign pixel_valid = r_pixelValid;
    assign mem_addr    = r_addr;
    assign con_count   = r_conCount;
    assign max_count   = r_maxCount;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized frame-level bench for conv_frame_sequencer with an image memory and datapath pulse model.
module tb_conv_frame_sequencer;

    localparam int IMG_W         = 28;
    localparam int IMG_H         = 28;
    localparam int KERNEL        = 3;
    localparam int POOL          = 2;
    localparam int ADDR_W        = 10;
    localparam int CNT_W         = 10;
    localparam int DRAIN_TIMEOUT = 1023;

    localparam int PIXELS    = IMG_W * IMG_H;
    localparam int CONV_OUTS = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);
    localparam int POOL_OUTS = ((IMG_W - KERNEL + 1) / POOL) * ((IMG_H - KERNEL + 1) / POOL);

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_data = 8'h00;
    logic [7:0]        pixel_out;
    logic              pixel_valid;
    logic              con_valid;
    logic              max_valid;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overrun;
    logic [CNT_W-1:0]  con_count;
    logic [CNT_W-1:0]  max_count;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0]       frame_cycles;
`endif

    logic [7:0] memArr [0:1023];

    int cyc           = 0;
    int compareCount  = 0;
    int mismatchCount = 0;
    int pixTotal      = 0;
    int pixStart      = 0;
    int lastPixCycle  = 0;
    int doneCount     = 0;
    int monIdx        = 0;
    bit holdCheckEn   = 1'b0;
    bit genActive     = 1'b0;

    int conEarly, conLate, maxEarly, maxLate;
    int sentCon, sentMax;
    int stallMode, stallLeft;
    bit did100, did783;

    conv_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .POOL(POOL),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stall(stall),
        .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_data(mem_data),
        .pixel_out(pixel_out),
        .pixel_valid(pixel_valid),
        .con_valid(con_valid),
        .max_valid(max_valid),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .overrun(overrun),
        .con_count(con_count),
        .max_count(max_count)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .frame_cycles(frame_cycles)
`endif
    );

    initial begin
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            mem_data <= memArr[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Pixel stream must replay memory in address order and hold its last value between valid cycles.
    always @(negedge clock) begin
        if (done) begin
            doneCount++;
        end
        if (pixel_valid) begin
            monIdx = pixTotal - pixStart;
            if (monIdx < PIXELS) begin
                checkOutput("pixelData", 32'(pixel_out), 32'(memArr[monIdx]));
            end else begin
                checkOutput("pixelExtra", monIdx + 1, PIXELS);
            end
            pixTotal++;
            lastPixCycle = cyc;
        end else if (holdCheckEn && (pixTotal > pixStart)) begin
            monIdx = pixTotal - pixStart - 1;
            if (monIdx < PIXELS) begin
                checkOutput("pixelHold", 32'(pixel_out), 32'(memArr[monIdx]));
            end
        end
    end

    task automatic driveDatapath();
        int pc;
        pc        = pixTotal - pixStart;
        con_valid = 1'b0;
        max_valid = 1'b0;
        if (genActive && busy && !done) begin
            if ((sentCon < conEarly) && ($urandom_range(0, 3) != 0)) begin
                con_valid = 1'b1;
                sentCon++;
            end
            if ((sentMax < maxEarly) && ($urandom_range(0, 3) == 0)) begin
                max_valid = 1'b1;
                sentMax++;
            end
            if (!con_valid && !max_valid && (pc >= PIXELS) && (sentCon >= conEarly) && (sentMax >= maxEarly)) begin
                if (sentMax < maxEarly + maxLate) begin
                    max_valid = 1'b1;
                    sentMax++;
                end else if (sentCon < conEarly + conLate) begin
                    con_valid = 1'b1;
                    sentCon++;
                end
            end
        end
        case (stallMode)
            1: begin
                if (stallLeft > 0) begin
                    stall = 1'b1;
                    stallLeft--;
                end else if (busy && !done && (mem_addr == 10'd100) && !did100) begin
                    did100    = 1'b1;
                    stall     = 1'b1;
                    stallLeft = 4;
                end else if (busy && !done && (mem_addr == 10'd783) && !did783) begin
                    did783 = 1'b1;
                    stall  = 1'b1;
                end else begin
                    stall = 1'b0;
                end
            end
            2:       stall = ($urandom_range(0, 7) == 0);
            default: stall = 1'b0;
        endcase
    endtask

    task automatic nextCycle();
        @(negedge clock);
        driveDatapath();
    endtask

    // Runs one frame from the current negedge: start, optional stray starts or abort, then end-of-frame checks.
    task automatic applyStimulus(input int cE, input int cL, input int mE, input int mL, input int sMode,
                                 input bit expTimeout, input bit busyStarts, input int abortAt);
        int  doneBefore;
        int  startCycle;
        int  conTotal;
        int  maxTotal;
        bit  sawDone;
        bit  pokedBusy;
        conTotal = cE + cL;
        maxTotal = mE + mL;
        for (int a = 0; a < 1024; a++) begin
            memArr[a] = 8'($urandom);
        end
        conEarly   = cE;
        conLate    = cL;
        maxEarly   = mE;
        maxLate    = mL;
        sentCon    = 0;
        sentMax    = 0;
        stallMode  = sMode;
        stallLeft  = 0;
        did100     = 1'b0;
        did783     = 1'b0;
        pixStart   = pixTotal;
        doneBefore = doneCount;
        genActive  = 1'b1;
        sawDone    = 1'b0;
        pokedBusy  = 1'b0;
        start      = 1'b1;
        nextCycle();
        start       = 1'b0;
        startCycle  = cyc;
        holdCheckEn = 1'b1;
        checkOutput("busyAfterStart", 32'(busy), 1);
        checkOutput("timeoutCleared", 32'(timeout), 0);
        checkOutput("overrunCleared", 32'(overrun), 0);
        checkOutput("conCleared", 32'(con_count), 0);
        checkOutput("maxCleared", 32'(max_count), 0);
        checkOutput("addrStart", 32'(mem_addr), 0);

        for (int w = 0; (w < 4000) && !sawDone; w++) begin
            nextCycle();
            start = 1'b0;
            if ((abortAt > 0) && ((pixTotal - pixStart) >= abortAt)) begin
                reset       = 1'b1;
                holdCheckEn = 1'b0;
                nextCycle();
                reset = 1'b0;
                checkOutput("abortBusy", 32'(busy), 0);
                checkOutput("abortPixValid", 32'(pixel_valid), 0);
                checkOutput("abortCon", 32'(con_count), 0);
                checkOutput("abortMax", 32'(max_count), 0);
                checkOutput("abortDone", 32'(done), 0);
                repeat (5) nextCycle();
                checkOutput("abortNoDone", doneCount - doneBefore, 0);
                checkOutput("abortStaysIdle", 32'(busy), 0);
                genActive = 1'b0;
                con_valid = 1'b0;
                max_valid = 1'b0;
                stall     = 1'b0;
                return;
            end
            if (busyStarts && !pokedBusy && ((pixTotal - pixStart) >= 300)) begin
                start     = 1'b1;
                pokedBusy = 1'b1;
            end
            if (done) begin
                sawDone = 1'b1;
            end
        end

        checkOutput("doneSeen", 32'(sawDone), 1);
        if (sawDone) begin
            checkOutput("busyInDone", 32'(busy), 1);
            checkOutput("pixelTotal", pixTotal - pixStart, PIXELS);
            checkOutput("conCount", 32'(con_count), (conTotal < CONV_OUTS) ? conTotal : CONV_OUTS);
            checkOutput("maxCount", 32'(max_count), (maxTotal < POOL_OUTS) ? maxTotal : POOL_OUTS);
            checkOutput("timeoutFlag", 32'(timeout), 32'(expTimeout));
            checkOutput("overrunFlag", 32'(overrun), 32'((conTotal > CONV_OUTS) || (maxTotal > POOL_OUTS)));
            if (expTimeout) begin
                checkOutput("drainLatency", cyc - lastPixCycle, DRAIN_TIMEOUT);
            end
`ifdef SEQ_CYCLE_COUNT_EN
            checkOutput("frameCycles", 32'(frame_cycles), cyc - startCycle);
`endif
            if (busyStarts) begin
                start = 1'b1;
            end
            nextCycle();
            start = 1'b0;
            checkOutput("doneOnce", doneCount - doneBefore, 1);
            checkOutput("doneLow", 32'(done), 0);
            checkOutput("idleAfterDone", 32'(busy), 0);
        end
        holdCheckEn = 1'b0;
        genActive   = 1'b0;
        con_valid   = 1'b0;
        max_valid   = 1'b0;
        stall       = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        con_valid = 1'b0;
        max_valid = 1'b0;
        stallMode = 0;
        repeat (3) @(negedge clock);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstPixValid", 32'(pixel_valid), 0);
        checkOutput("rstPixOut", 32'(pixel_out), 0);
        checkOutput("rstTimeout", 32'(timeout), 0);
        checkOutput("rstOverrun", 32'(overrun), 0);
        checkOutput("rstCon", 32'(con_count), 0);
        checkOutput("rstMax", 32'(max_count), 0);
        checkOutput("rstAddr", 32'(mem_addr), 0);
        checkOutput("rstRdEn", 32'(mem_rd_en), 0);
        reset = 1'b0;

        con_valid = 1'b1;
        max_valid = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("idleConIgnored", 32'(con_count), 0);
        checkOutput("idleMaxIgnored", 32'(max_count), 0);
        checkOutput("idleNoOverrun", 32'(overrun), 0);
        con_valid = 1'b0;
        max_valid = 1'b0;
        @(negedge clock);

        $display("[TB] nominal frame");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 0, 1'b0, 1'b0, 0);
        $display("[TB] scripted stall frame");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 1, 1'b0, 1'b0, 0);
        $display("[TB] random stall frame");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 2, 1'b0, 1'b0, 0);
        $display("[TB] missing conv output frame");
        applyStimulus(CONV_OUTS - 1, 0, POOL_OUTS, 0, 0, 1'b1, 1'b0, 0);
        $display("[TB] extra pool output frame with stray starts");
        applyStimulus(CONV_OUTS - 1, 1, POOL_OUTS, 1, 2, 1'b0, 1'b1, 0);
        $display("[TB] back-to-back frame");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 2, 1'b0, 1'b0, 0);
        $display("[TB] aborted frame");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 0, 1'b0, 1'b0, 400);
        $display("[TB] frame after abort");
        applyStimulus(CONV_OUTS, 0, POOL_OUTS, 0, 2, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
